// File: rtl/dac_frame_serializer.sv
// dac_frame_serializer: one-deep buffered, framed MSB-first SPI (mode 0) serializer for a DAC.
//   clk, rst        : clock, synchronous active-high reset
//   in_data/valid   : sample input, accepted when in_valid && in_ready
//   in_ready        : buffer empty
//   sclk/mosi/csb   : registered SPI outputs
//   frame_done      : one-cycle pulse as csb returns high
//   overrun         : sticky, write attempted while buffer full
module dac_frame_serializer #(
    parameter int WORD_WIDTH = 16,
    parameter int CLK_DIV    = 2,
    parameter int CS_GAP     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  csb,
    output logic                  frame_done,
    output logic                  overrun
);
    localparam int BW = $clog2(WORD_WIDTH + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] buf_q, buf_d, shreg_q, shreg_d, sh_next;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]            div_cnt_q, div_cnt_d;
    logic                  buf_full_q, buf_full_d, sclk_q, sclk_d, mosi_q, mosi_d;
    logic                  csb_q, csb_d, done_q, done_d, overrun_q, overrun_d;
    logic                  accept, start, div_wrap;
    always_comb begin
        accept    = in_valid && !buf_full_q;
        div_wrap  = div_cnt_q == 8'(CLK_DIV - 1);
        sh_next   = shreg_q << 1;
        start     = 1'b0;
        state_d   = state_q;
        buf_d     = accept ? in_data : buf_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        csb_d     = csb_q;
        done_d    = 1'b0;
        overrun_d = overrun_q || (in_valid && buf_full_q);
        case (state_q)
            IDLE: start = buf_full_q;
            SHIFT: begin
                div_cnt_d = div_wrap ? 8'd0 : div_cnt_q + 8'd1;
                if (div_wrap) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else if (bit_cnt_q == BW'(WORD_WIDTH - 1)) begin
                        state_d   = GAP;
                        sclk_d    = 1'b0;
                        mosi_d    = 1'b0;
                        csb_d     = 1'b1;
                        done_d    = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        sclk_d    = 1'b0;
                        shreg_d   = sh_next;
                        mosi_d    = sh_next[WORD_WIDTH-1];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            GAP: begin
                // The frame_done cycle is gap cycle 0; a pending word starts
                // on the edge that ends the gap so csb stays high exactly CS_GAP.
                if (div_cnt_q == 8'(CS_GAP - 1)) begin
                    state_d   = IDLE;
                    div_cnt_d = 8'd0;
                    start     = buf_full_q;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                csb_d     = 1'b1;
                sclk_d    = 1'b0;
                mosi_d    = 1'b0;
                div_cnt_d = 8'd0;
                bit_cnt_d = '0;
            end
        endcase
        if (start) begin
            state_d   = SHIFT;
            shreg_d   = buf_q;
            mosi_d    = buf_q[WORD_WIDTH-1];
            csb_d     = 1'b0;
            sclk_d    = 1'b0;
            div_cnt_d = 8'd0;
            bit_cnt_d = '0;
        end
        buf_full_d = accept || (buf_full_q && !start);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            div_cnt_q  <= 8'd0;
            buf_full_q <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            csb_q      <= 1'b1;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= div_cnt_d;
            buf_full_q <= buf_full_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            csb_q      <= csb_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end
    assign in_ready   = !buf_full_q;
    assign sclk       = sclk_q;
    assign mosi       = mosi_q;
    assign csb        = csb_q;
    assign frame_done = done_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_dac_frame_serializer.sv
// tb_dac_frame_serializer: directed checks of framing, handshake, overrun and reset.
module tb_dac_frame_serializer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] d0 = '0, d1 = '0;
    logic [1:0]  v = '0;
    wire  [1:0]  rdy_w, sclk_w, mosi_w, csb_w, done_w, ovr_w;
    logic        mon_clr = 1'b1;
    int          total = 0, passed = 0;
    logic [15:0] words [2][8];
    int          lows [2][8], rises [2][8], gaps [2][8];
    int          nw [2], done_cnt [2], low_cnt [2], high_cnt [2], nrise [2];
    logic [15:0] word [2];
    logic [1:0]  prev_csb = 2'b11, prev_sclk = 2'b00;
    always #5 clk = ~clk;
    dac_frame_serializer u_dut0 (
        .clk(clk), .rst(rst), .in_data(d0), .in_valid(v[0]), .in_ready(rdy_w[0]),
        .sclk(sclk_w[0]), .mosi(mosi_w[0]), .csb(csb_w[0]), .frame_done(done_w[0]), .overrun(ovr_w[0])
    );
    dac_frame_serializer #(.WORD_WIDTH(16), .CLK_DIV(1), .CS_GAP(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_data(d1), .in_valid(v[1]), .in_ready(rdy_w[1]),
        .sclk(sclk_w[1]), .mosi(mosi_w[1]), .csb(csb_w[1]), .frame_done(done_w[1]), .overrun(ovr_w[1])
    );
    // Independent SPI receiver: decodes words on sclk rising edges and measures csb timing.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mon_clr) begin
                nw[k] = 0; done_cnt[k] = 0; low_cnt[k] = 0; high_cnt[k] = 0; nrise[k] = 0; word[k] = '0;
            end else begin
                if (done_w[k]) done_cnt[k]++;
                if (csb_w[k] && !prev_csb[k]) begin
                    if (nw[k] < 8) begin
                        words[k][nw[k]] = word[k]; lows[k][nw[k]] = low_cnt[k]; rises[k][nw[k]] = nrise[k];
                    end
                    nw[k]++;
                    high_cnt[k] = 1;
                end else if (csb_w[k]) high_cnt[k]++;
                if (!csb_w[k] && prev_csb[k]) begin
                    if (nw[k] < 8) gaps[k][nw[k]] = high_cnt[k];
                    low_cnt[k] = 1; word[k] = '0; nrise[k] = 0;
                end else if (!csb_w[k]) low_cnt[k]++;
                if (!csb_w[k] && sclk_w[k] && !prev_sclk[k]) begin
                    word[k] = {word[k][14:0], mosi_w[k]};
                    nrise[k]++;
                end
            end
            prev_csb[k]  = csb_w[k];
            prev_sclk[k] = sclk_w[k];
        end
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic mon_clear();
        @(posedge clk); #1 mon_clr = 1'b1;
        @(negedge clk); #1 mon_clr = 1'b0;
    endtask
    task automatic send(input int k, input logic [15:0] d);
        int n = 0;
        @(negedge clk);
        while (!rdy_w[k] && n < 2000) begin @(negedge clk); n++; end
        chk("send_ready", 32'(rdy_w[k]), 1);
        if (k == 0) d0 = d; else d1 = d;
        v[k] = 1'b1;
        @(posedge clk); #1 v[k] = 1'b0;
    endtask
    task automatic wait_frames(input int k, input int n);
        int c = 0;
        while (nw[k] < n && c < 5000) begin @(negedge clk); c++; end
        chk("frame_count", nw[k], n);
    endtask
    initial begin
        int bad, first_done;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_csb", 32'(csb_w[0]), 1);
        chk("rst_sclk", 32'(sclk_w[0]), 0);
        chk("rst_mosi", 32'(mosi_w[0]), 0);
        chk("rst_done", 32'(done_w[0]), 0);
        chk("rst_ready", 32'(rdy_w[0]), 1);
        chk("rst_ovr", 32'(ovr_w[0]), 0);
        rst = 1'b0; mon_clr = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (!csb_w[0] || sclk_w[0] || mosi_w[0] || !rdy_w[0] || done_w[0]) bad++;
        end
        chk("idle_bad", bad, 0);
        chk("idle_done", done_cnt[0], 0);
        // single word A5C3
        @(negedge clk); d0 = 16'hA5C3; v[0] = 1'b1;
        @(posedge clk); #1 v[0] = 1'b0;
        chk("csb_at_t", 32'(csb_w[0]), 1);
        first_done = 0;
        for (int c = 1; c <= 70; c++) begin
            @(posedge clk); #1;
            if (c == 1) chk("csb_at_t1", 32'(csb_w[0]), 0);
            if (done_w[0] && first_done == 0) first_done = c;
        end
        chk("done_at", first_done, 65);
        @(negedge clk);
        chk("a5_frames", nw[0], 1);
        chk("a5_word", words[0][0], 16'hA5C3);
        chk("a5_low", lows[0][0], 64);
        chk("a5_rises", rises[0][0], 16);
        chk("a5_done_cnt", done_cnt[0], 1);
        // back-to-back
        mon_clear();
        send(0, 16'h0001);
        send(0, 16'hFFFE);
        chk("b2b_ready_low", 32'(rdy_w[0]), 0);
        wait_frames(0, 2);
        chk("b2b_w0", words[0][0], 16'h0001);
        chk("b2b_w1", words[0][1], 16'hFFFE);
        chk("b2b_gap", gaps[0][1], 2);
        chk("b2b_low1", lows[0][1], 64);
        chk("b2b_ready_hi", 32'(rdy_w[0]), 1);
        chk("b2b_done", done_cnt[0], 2);
        // overrun
        repeat (5) @(negedge clk);
        mon_clear();
        send(0, 16'h1234);
        send(0, 16'h5678);
        chk("ovr_ready_low", 32'(rdy_w[0]), 0);
        chk("ovr_pre", 32'(ovr_w[0]), 0);
        @(negedge clk); d0 = 16'h9ABC; v[0] = 1'b1;
        @(posedge clk); #1 v[0] = 1'b0;
        chk("ovr_set", 32'(ovr_w[0]), 1);
        wait_frames(0, 2);
        repeat (20) @(negedge clk);
        chk("ovr_nframes", nw[0], 2);
        chk("ovr_w0", words[0][0], 16'h1234);
        chk("ovr_w1", words[0][1], 16'h5678);
        chk("ovr_sticky", 32'(ovr_w[0]), 1);
        // reset mid-frame
        mon_clear();
        send(0, 16'hFFFF);
        repeat (20) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_csb", 32'(csb_w[0]), 1);
        chk("mid_sclk", 32'(sclk_w[0]), 0);
        chk("mid_ready", 32'(rdy_w[0]), 1);
        chk("mid_ovr", 32'(ovr_w[0]), 0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("mid_no_done", done_cnt[0], 0);
        mon_clear();
        send(0, 16'h00F0);
        wait_frames(0, 1);
        chk("mid_word", words[0][0], 16'h00F0);
        chk("mid_low", lows[0][0], 64);
        chk("mid_done", done_cnt[0], 1);
        // CLK_DIV=1, CS_GAP=1
        mon_clear();
        send(1, 16'h8001);
        send(1, 16'h7FFE);
        wait_frames(1, 2);
        chk("d1_w0", words[1][0], 16'h8001);
        chk("d1_w1", words[1][1], 16'h7FFE);
        chk("d1_low0", lows[1][0], 32);
        chk("d1_rises0", rises[1][0], 16);
        chk("d1_gap", gaps[1][1], 1);
        chk("d1_done", done_cnt[1], 2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
